// File: rtl/game_tick_ctrl.sv
// Clock-enable scheduler for the BlockyRoads core: pixel/scan dividers plus a RUN/PAUSED/HALT game-tick sequencer.
// Optional speed ramp is enabled by defining GAME_TICK_RAMP_EN.
module game_tick_ctrl #(
  parameter int unsigned PIX_DIV        = 4,
  parameter int unsigned SCAN_DIV       = 62500,
  parameter int unsigned BASE_PERIOD    = 2000000,
  parameter int unsigned PERIOD_STEP    = 200000,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned LEVEL_UP_TICKS = 500
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       pause_req,
  input  logic       resume,
  input  logic       crash,
  output logic       pix_en,
  output logic       scan_en,
  output logic       game_tick,
  output logic       pause_ack,
  output logic       running,
  output logic [1:0] state,
  output logic [2:0] speed_level
);

  localparam int unsigned PIX_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (MAX_LEVEL > 7 || LEVEL_UP_TICKS == 0 ||
      BASE_PERIOD < MAX_LEVEL * PERIOD_STEP + 2) begin : g_cfg_err
    $error("game_tick_ctrl: invalid speed-ramp parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_HALT   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [31:0]       gcnt_q, gcnt_d;
  logic [31:0]       period_d;
  logic [2:0]        level_q, level_d;
  logic              pix_en_q, pix_en_d;
  logic              scan_en_q, scan_en_d;
  logic              tick_q, tick_d;
  logic              ack_q, run_q;
  logic              restart;

  function automatic logic [31:0] period_of(input logic [2:0] lvl);
    return 32'(BASE_PERIOD) - 32'(lvl) * 32'(PERIOD_STEP);
  endfunction

  assign restart = start && (state_q == ST_IDLE || state_q == ST_HALT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (crash)          state_d = ST_HALT;
        else if (pause_req) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (crash)       state_d = ST_HALT;
        else if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_d  = (pix_cnt_q == PIX_W'(PIX_DIV - 1)) ? '0 : pix_cnt_q + PIX_W'(1);
    scan_cnt_d = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + SCAN_W'(1);
    pix_en_d   = (pix_cnt_d == PIX_W'(PIX_DIV - 1));
    scan_en_d  = (scan_cnt_d == SCAN_W'(SCAN_DIV - 1));
  end

  // tick_q is high exactly while RUN with gcnt at the last count of the period
  always_comb begin
    gcnt_d = gcnt_q;
    if (restart)                gcnt_d = '0;
    else if (state_q == ST_RUN) gcnt_d = tick_q ? '0 : gcnt_q + 32'd1;
    period_d = period_of(level_d);
    tick_d   = (state_d == ST_RUN) && (gcnt_d == period_d - 32'd1);
  end

`ifdef GAME_TICK_RAMP_EN
  localparam int unsigned LCNT_W = (LEVEL_UP_TICKS > 1) ? $clog2(LEVEL_UP_TICKS) : 1;

  logic [LCNT_W-1:0] lcnt_q, lcnt_d;

  always_comb begin
    lcnt_d  = lcnt_q;
    level_d = level_q;
    if (restart) begin
      lcnt_d  = '0;
      level_d = '0;
    end else if (tick_q) begin
      if (lcnt_q == LCNT_W'(LEVEL_UP_TICKS - 1)) begin
        lcnt_d = '0;
        if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
      end else begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      lcnt_q  <= '0;
      level_q <= '0;
    end else begin
      lcnt_q  <= lcnt_d;
      level_q <= level_d;
    end
  end
`else
  assign level_q = 3'd0;
  assign level_d = 3'd0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      scan_cnt_q <= '0;
      gcnt_q     <= '0;
      pix_en_q   <= 1'b0;
      scan_en_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      gcnt_q     <= gcnt_d;
      pix_en_q   <= pix_en_d;
      scan_en_q  <= scan_en_d;
      tick_q     <= tick_d;
      ack_q      <= (state_d == ST_PAUSED);
      run_q      <= (state_d == ST_RUN);
    end
  end

  assign pix_en      = pix_en_q;
  assign scan_en     = scan_en_q;
  assign game_tick   = tick_q;
  assign pause_ack   = ack_q;
  assign running     = run_q;
  assign state       = state_q;
  assign speed_level = level_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Scoreboard bench for game_tick_ctrl: per-cycle expected outputs from a behavioural model,
// popped and compared by a separate monitor; plus directed tick-spacing and reset checks.
module tb_game_tick_ctrl;

  localparam int PIX  = 4;
  localparam int SCAN = 8;
  localparam int BASE = 10;
  localparam int STEP = 2;
  localparam int MAXL = 3;
  localparam int LUT  = 3;
`ifdef GAME_TICK_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0, pause_req = 1'b0, resume = 1'b0, crash = 1'b0;
  logic       pix_en, scan_en, game_tick, pause_ack, running;
  logic [1:0] state;
  logic [2:0] speed_level;

  game_tick_ctrl #(
    .PIX_DIV(PIX), .SCAN_DIV(SCAN), .BASE_PERIOD(BASE),
    .PERIOD_STEP(STEP), .MAX_LEVEL(MAXL), .LEVEL_UP_TICKS(LUT)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .pause_req(pause_req),
    .resume(resume), .crash(crash), .pix_en(pix_en), .scan_en(scan_en),
    .game_tick(game_tick), .pause_ack(pause_ack), .running(running),
    .state(state), .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pix, scan, tick, ack, run;
    logic [1:0] st;
    logic [2:0] lvl;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, exp_v;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Model: cycles since reset release, game state (0 idle,1 run,2 paused,3 halt),
  // position inside the current game period, and ticks since the game started.
  int m_cyc, m_state, m_elapsed, m_ticks;

  function automatic int m_level();
    int l;
    if (!RAMP) return 0;
    l = m_ticks / LUT;
    return (l > MAXL) ? MAXL : l;
  endfunction

  function automatic int m_period();
    return BASE - m_level() * STEP;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_elapsed = 0; m_ticks = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit r, input bit c);
    int prev;
    prev = m_state;
    if (prev == 1) begin
      if (m_elapsed == m_period() - 1) begin
        m_elapsed = 0;
        m_ticks++;
      end else begin
        m_elapsed++;
      end
    end
    case (prev)
      0, 3: if (s) begin m_state = 1; m_elapsed = 0; m_ticks = 0; end
      1: begin
        if (c)      m_state = 3;
        else if (p) m_state = 2;
      end
      2: begin
        if (c)      m_state = 3;
        else if (r) m_state = 1;
      end
      default: m_state = 0;
    endcase
    m_cyc++;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.pix  = (m_cyc % PIX) == PIX - 1;
    o.scan = (m_cyc % SCAN) == SCAN - 1;
    o.tick = (m_state == 1) && (m_elapsed == m_period() - 1);
    o.ack  = (m_state == 2);
    o.run  = (m_state == 1);
    o.st   = 2'(m_state);
    o.lvl  = 3'(m_level());
    return o;
  endfunction

  // Called at a falling edge: drive inputs for the next rising edge and queue the expectation.
  task automatic step(input bit s, input bit p, input bit r, input bit c);
    start = s; pause_req = p; resume = r; crash = c;
    model_edge(s, p, r, c);
    exp_q.push_back(model_out());
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({pix_en, scan_en, game_tick, pause_ack, running, state, speed_level} !== 10'd0) begin
      errors++;
      $display("FAIL %s: got pix=%0b scan=%0b tick=%0b ack=%0b run=%0b st=%0d lvl=%0d, required all zero",
               name, pix_en, scan_en, game_tick, pause_ack, running, state, speed_level);
    end
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      got = '{pix_en, scan_en, game_tick, pause_ack, running, state, speed_level};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: output present with no expectation queued", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          errors++;
          $display("FAIL outputs t=%0t got pix=%0b scan=%0b tick=%0b ack=%0b run=%0b st=%0d lvl=%0d required pix=%0b scan=%0b tick=%0b ack=%0b run=%0b st=%0d lvl=%0d",
                   $time, got.pix, got.scan, got.tick, got.ack, got.run, got.st, got.lvl,
                   exp_v.pix, exp_v.scan, exp_v.tick, exp_v.ack, exp_v.run, exp_v.st, exp_v.lvl);
        end
      end
    end
  end

  initial begin
    int n, last, cum, k, per, lv, nexp;
    int iv[$];
    int ivexp[$];
    bit pr;

    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset_hold");
    clr = 1'b0;

    // Idle with noise on inputs that IDLE must ignore.
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Start and observe tick spacing through the speed ramp.
    n = 0; last = -1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 80; i++) begin
      if (game_tick === 1'b1) begin
        iv.push_back(n - last);
        last = n;
      end
      if (i < 80) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n++;
      end
    end
    cum = 0; k = 0;
    forever begin
      lv  = RAMP ? ((k / LUT > MAXL) ? MAXL : k / LUT) : 0;
      per = BASE - lv * STEP;
      if (cum + per > 80) break;
      cum += per;
      ivexp.push_back(per);
      k++;
    end
    nexp = ivexp.size();
    checks++;
    if (iv.size() != nexp) begin
      errors++;
      $display("FAIL tick_count: got %0d ticks, required %0d", iv.size(), nexp);
    end
    for (int i = 0; i < nexp && i < iv.size(); i++) begin
      checks++;
      if (iv[i] != ivexp[i]) begin
        errors++;
        $display("FAIL tick_interval[%0d]: got %0d cycles, required %0d", i, iv[i], ivexp[i]);
      end
    end

    // Pause for 25 cycles, resume, run on.
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Crash together with pause_req, linger in HALT, restart.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Restart, then clear mid-game while gcnt is 5.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    clr = 1'b1;
    #1;
    check_reset("clr_midrun");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset("clr_held");
    clr = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized play.
    pr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) pr = ~pr;
      step(1'($urandom_range(0, 59) == 0), pr,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
